// File: rtl/mpl_macro_pipe_array.sv
// mpl_macro_pipe_array: CHANNELS independent valid/ready register chains of DEPTH stages with lockstep pop, flush and per-channel counters
module mpl_macro_pipe_array #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2,
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 16,
  parameter int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  input  logic                      lockstep,
  input  logic                      flush,
  output logic [CHANNELS*OCC_W-1:0] occupancy,
  output logic [CHANNELS*CNT_W-1:0] xfer_count
);
  logic [CHANNELS-1:0] last_v;
  logic [CHANNELS-1:0] pop;
  logic                all_v;

  assign all_v = &last_v;
  // In lockstep a channel's valid only means something once every channel holds a beat.
  assign out_valid = flush ? '0 : (lockstep ? {CHANNELS{all_v}} : last_v);
  // Lockstep pops every channel together, and only when every sink is ready.
  assign pop = flush ? '0 : (lockstep ? {CHANNELS{all_v & (&out_ready)}} : last_v & out_ready);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [OCC_W-1:0] occ;

    // Ready ripples back from the sink so an empty stage anywhere lets the chain close up.
    always_comb begin
      rdy[DEPTH-1] = !v[DEPTH-1] | pop[c];
      for (int k = DEPTH - 2; k >= 0; k--) rdy[k] = !v[k] | rdy[k+1];
    end

    // Each stage's upstream source: the input port for stage 0, the previous stage otherwise.
    always_comb begin
      up_v[0] = in_valid[c];
      up_d[0] = in_data[c*WIDTH +: WIDTH];
      for (int k = 1; k < DEPTH; k++) begin
        up_v[k] = v[k-1];
        up_d[k] = d[k-1];
      end
    end

    // Stage valids and the transfer counter; flush empties the chain without counting.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v   <= '0;
        cnt <= '0;
      end else if (flush) begin
        v <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) if (rdy[k]) v[k] <= up_v[k];
        cnt <= cnt + CNT_W'(pop[c]);
      end
    end

    // Data has no reset; contents of empty stages are don't-care.
    always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) if (rdy[k]) d[k] <= up_d[k];
    end

    // Occupancy is a popcount of the stage valids.
    always_comb begin
      occ = '0;
      for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(v[k]);
    end

    assign last_v[c]                      = v[DEPTH-1];
    assign in_ready[c]                    = rdy[0] & !flush;
    assign out_data[c*WIDTH +: WIDTH]     = d[DEPTH-1];
    assign occupancy[c*OCC_W +: OCC_W]    = occ;
    assign xfer_count[c*CNT_W +: CNT_W]   = cnt;
  end
endmodule

// File: tb/tb_mpl_macro_pipe_array.sv
// tb_mpl_macro_pipe_array: scoreboard bench for the multi-channel pipe array (4 channels, depth 2, 8-bit, 4-bit counters)
module tb_mpl_macro_pipe_array;
  logic        clk = 0;
  logic        rst_n;
  logic [3:0]  in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        lockstep, flush;
  logic [7:0]  occupancy;
  logic [15:0] xfer_count;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  q [4][$];
  logic [7:0]  e;

  mpl_macro_pipe_array #(.CHANNELS(4), .DEPTH(2), .WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .lockstep(lockstep),
    .flush(flush), .occupancy(occupancy), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    for (int c = 0; c < 4; c++) q[c].delete();
  endtask

  // Monitor: a transfer happens at the coming edge when valid and the mode's ready condition hold.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c] && (lockstep ? &out_ready : out_ready[c])) begin
          n_vec++;
          if (q[c].size() == 0) begin
            n_err++;
            $display("FAIL out_ch%0d: got unexpected beat %h expected none", c, out_data[c*8 +: 8]);
          end else begin
            e = q[c].pop_front();
            if (out_data[c*8 +: 8] !== e) begin
              n_err++;
              $display("FAIL out_ch%0d: got %h expected %h", c, out_data[c*8 +: 8], e);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; out_ready = 0; lockstep = 0; flush = 0;
    tick(); tick();
    check("rst_occ", occupancy, 8'h00);
    check("rst_ovalid", out_valid, 4'h0);
    check("rst_cnt", xfer_count, 16'h0000);
    check("rst_iready", in_ready, 4'hF);
    rst_n = 1;
    tick();
    // single beat latency on channel 0
    out_ready = 4'hF;
    in_valid = 4'b0001; in_data[7:0] = 8'h5A;
    #1 check("t1_iready", in_ready[0], 1'b1);
    q[0].push_back(8'h5A);
    tick();
    in_valid = 0;
    check("t1_ov_cyc1", out_valid, 4'h0);
    check("t1_occ_cyc1", occupancy, 8'h01);
    tick();
    check("t1_ov_cyc2", out_valid, 4'b0001);
    check("t1_data", out_data[7:0], 8'h5A);
    tick();
    check("t1_cnt", xfer_count, 16'h0001);
    check("t1_ov_after", out_valid, 4'h0);
    // back-to-back burst on all channels
    for (int b = 0; b < 8; b++) begin
      in_valid = 4'hF;
      in_data = {4{8'(b)}};
      #1 check("t2_iready", in_ready, 4'hF);
      for (int c = 0; c < 4; c++) q[c].push_back(8'(b));
      tick();
    end
    in_valid = 0;
    tick(); tick(); tick();
    check("t2_cnt", xfer_count, 16'h8889);
    check("t2_occ", occupancy, 8'h00);
    // backpressure on channel 2
    out_ready = 4'b1011;
    in_valid = 4'b0100; in_data[23:16] = 8'hA0;
    #1 check("t3_iready_a0", in_ready[2], 1'b1);
    q[2].push_back(8'hA0);
    tick();
    in_data[23:16] = 8'hA1;
    #1 check("t3_iready_a1", in_ready[2], 1'b1);
    q[2].push_back(8'hA1);
    tick();
    in_data[23:16] = 8'hA2;
    #1 check("t3_iready_full", in_ready[2], 1'b0);
    check("t3_occ_full", occupancy[5:4], 2'd2);
    out_ready = 4'hF;
    #1 check("t3_iready_rel", in_ready[2], 1'b1);
    q[2].push_back(8'hA2);
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    check("t3_occ_drain", occupancy, 8'h00);
    check("t3_cnt", xfer_count, 16'h8B89);
    // lockstep
    out_ready = 0; lockstep = 1;
    in_valid = 4'b0111; in_data = 32'h00B2B1B0;
    #1 check("t4_iready", in_ready, 4'hF);
    q[0].push_back(8'hB0); q[1].push_back(8'hB1); q[2].push_back(8'hB2);
    tick();
    in_valid = 0;
    tick();
    check("t4_ov_partial", out_valid, 4'h0);
    check("t4_occ_partial", occupancy, 8'h15);
    in_valid = 4'b1000; in_data[31:24] = 8'hB3;
    #1 check("t4_iready3", in_ready[3], 1'b1);
    q[3].push_back(8'hB3);
    tick();
    in_valid = 0;
    tick();
    check("t4_ov_all", out_valid, 4'hF);
    out_ready = 4'b1011;
    tick();
    check("t4_ov_hold", out_valid, 4'hF);
    check("t4_cnt_hold", xfer_count, 16'h8B89);
    out_ready = 4'hF;
    tick();
    check("t4_cnt_pop", xfer_count, 16'h9C9A);
    check("t4_ov_after", out_valid, 4'h0);
    lockstep = 0;
    // fill then flush with pop requested
    out_ready = 0;
    in_valid = 4'hF; in_data = 32'hC3C2C1C0;
    #1 check("t5_iready0", in_ready, 4'hF);
    for (int c = 0; c < 4; c++) q[c].push_back(8'hC0 + 8'(c));
    tick();
    in_data = 32'hC7C6C5C4;
    for (int c = 0; c < 4; c++) q[c].push_back(8'hC4 + 8'(c));
    tick();
    in_valid = 0;
    #1 check("t5_occ_full", occupancy, 8'hAA);
    check("t5_iready_full", in_ready, 4'h0);
    out_ready = 4'hF; flush = 1;
    clear_q();
    #1 check("t5_ov_flush", out_valid, 4'h0);
    check("t5_iready_flush", in_ready, 4'h0);
    tick();
    flush = 0;
    #1 check("t5_occ_after", occupancy, 8'h00);
    check("t5_ov_after", out_valid, 4'h0);
    check("t5_cnt_after", xfer_count, 16'h9C9A);
    // asynchronous reset mid-stream on channel 1
    in_valid = 4'b0010;
    for (int b = 0; b < 3; b++) begin
      in_data[15:8] = 8'hD0 + 8'(b);
      #1 check("t6_iready", in_ready[1], 1'b1);
      q[1].push_back(8'hD0 + 8'(b));
      tick();
    end
    rst_n = 0; in_valid = 0;
    clear_q();
    #1 check("t6_rst_ov", out_valid, 4'h0);
    check("t6_rst_occ", occupancy, 8'h00);
    check("t6_rst_cnt", xfer_count, 16'h0000);
    tick();
    rst_n = 1;
    #1 check("t6_iready_after", in_ready, 4'hF);
    // 17 transfers on channel 1 wrap the 4-bit counter to 1
    in_valid = 4'b0010;
    for (int b = 0; b < 17; b++) begin
      in_data[15:8] = 8'hE0 + 8'(b);
      #1 check("t7_iready", in_ready[1], 1'b1);
      q[1].push_back(8'hE0 + 8'(b));
      tick();
    end
    in_valid = 0;
    tick(); tick(); tick();
    check("t7_cnt_wrap", xfer_count, 16'h0010);
    check("sb_empty", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
